// File: rtl/cmos_nor2_switch_model_pkg.sv
// Shared constants, node-resolution enum and resolver for the clocked CMOS NOR2 switch model.
// Default delays describe the reference cell's characterised transistors.
package cmos_nor2_switch_model_pkg;

  localparam int DEF_NMOS_A_DLY = 2;
  localparam int DEF_NMOS_B_DLY = 2;
  localparam int DEF_PMOS_A_DLY = 1;
  localparam int DEF_PMOS_B_DLY = 2;

  typedef enum logic [1:0] {
    DRIVE0,
    DRIVE1,
    SHARE,
    HOLD
  } node_res_e;

  // Pull-down wins over pull-up; with neither conducting, an open pmos_b
  // shares charge from w5 onto the output, otherwise the output keeps its charge.
  function automatic node_res_e resolve_out(input logic pd, input logic pu,
                                            input logic pmos_b_on);
    node_res_e res;
    if (pd) begin
      res = DRIVE0;
    end else if (pu) begin
      res = DRIVE1;
    end else if (pmos_b_on) begin
      res = SHARE;
    end else begin
      res = HOLD;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmos_nor2_switch_model_if.sv
// Gate inputs and resolved node/flag outputs of the NOR2 switch model.
interface cmos_nor2_switch_model_if;

  logic a;
  logic b;
  logic nor_out;
  logic w5_node;
  logic contention;
  logic floating;

  modport master (
    output a,
    output b,
    input  nor_out,
    input  w5_node,
    input  contention,
    input  floating
  );

  modport slave (
    input  a,
    input  b,
    output nor_out,
    output w5_node,
    output contention,
    output floating
  );

endinterface

// File: rtl/cmos_nor2_switch_model_gate_delay_line.sv
// Per-transistor gate delay: DEPTH-stage shift register, last stage is the effective gate.
module cmos_nor2_switch_model_gate_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Clearing every stage on reset discards any gate value still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/cmos_nor2_switch_model.sv
// Clocked switch-level NOR2: parallel nmos pull-down, series pmos pull-up through node w5,
// with charge retention on undriven nodes and contention/floating flags.
module cmos_nor2_switch_model
  import cmos_nor2_switch_model_pkg::*;
#(
  parameter int NMOS_A_DLY = DEF_NMOS_A_DLY,
  parameter int NMOS_B_DLY = DEF_NMOS_B_DLY,
  parameter int PMOS_A_DLY = DEF_PMOS_A_DLY,
  parameter int PMOS_B_DLY = DEF_PMOS_B_DLY
) (
  input logic                     clk,
  input logic                     rst_n,
  cmos_nor2_switch_model_if.slave bus
);

  logic gate_na;
  logic gate_nb;
  logic gate_pa;
  logic gate_pb;

  cmos_nor2_switch_model_gate_delay_line #(.DEPTH(NMOS_A_DLY)) u_dly_nmos_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.a),
    .q     (gate_na)
  );

  cmos_nor2_switch_model_gate_delay_line #(.DEPTH(NMOS_B_DLY)) u_dly_nmos_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.b),
    .q     (gate_nb)
  );

  cmos_nor2_switch_model_gate_delay_line #(.DEPTH(PMOS_A_DLY)) u_dly_pmos_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.a),
    .q     (gate_pa)
  );

  cmos_nor2_switch_model_gate_delay_line #(.DEPTH(PMOS_B_DLY)) u_dly_pmos_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.b),
    .q     (gate_pb)
  );

  logic      nmos_a_on;
  logic      nmos_b_on;
  logic      pmos_a_on;
  logic      pmos_b_on;
  logic      pd;
  logic      pu;
  node_res_e out_res;

  always_comb begin
    nmos_a_on = gate_na;
    nmos_b_on = gate_nb;
    pmos_a_on = ~gate_pa;
    pmos_b_on = ~gate_pb;
    pd        = nmos_a_on | nmos_b_on;
    pu        = pmos_a_on & pmos_b_on;
    out_res   = resolve_out(pd, pu, pmos_b_on);
  end

  logic nor_q;
  logic w5_q;
  logic contention_q;
  logic floating_q;

  // Charge sharing reads the pre-edge w5 value, so the output never sees
  // a w5 update made at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nor_q        <= 1'b1;
      w5_q         <= 1'b1;
      contention_q <= 1'b0;
      floating_q   <= 1'b0;
    end else begin
      if (pmos_a_on) begin
        w5_q <= 1'b1;
      end else if (pmos_b_on && pd) begin
        w5_q <= 1'b0;
      end
      case (out_res)
        DRIVE0:  nor_q <= 1'b0;
        DRIVE1:  nor_q <= 1'b1;
        SHARE:   nor_q <= w5_q;
        HOLD:    nor_q <= nor_q;
        default: nor_q <= nor_q;
      endcase
      contention_q <= pd & pu;
      floating_q   <= ~pd & ~pu;
    end
  end

  assign bus.nor_out    = nor_q;
  assign bus.w5_node    = w5_q;
  assign bus.contention = contention_q;
  assign bus.floating   = floating_q;

endmodule

// File: tb/tb_cmos_nor2_switch_model.sv
// Bench for the NOR2 switch model: default-delay instance plus a slow VDD-side pmos instance,
// both driven with the same gate inputs and compared against a history-based reference model.
module tb_cmos_nor2_switch_model;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cmos_nor2_switch_model_if bus0 ();
  cmos_nor2_switch_model_if bus1 ();

  cmos_nor2_switch_model dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  cmos_nor2_switch_model #(.PMOS_A_DLY(3)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic cur_a;
  logic cur_b;

  // Reference model: each transistor's gate is simply the input sampled D edges ago.
  int dly_na [2] = '{2, 2};
  int dly_nb [2] = '{2, 2};
  int dly_pa [2] = '{1, 3};
  int dly_pb [2] = '{2, 2};
  bit hist_a [$];
  bit hist_b [$];
  bit m_nor  [2];
  bit m_w5   [2];
  bit m_cont [2];
  bit m_flt  [2];

  function automatic bit gate_at(input bit q[$], input int d);
    if (q.size() < d) return 1'b0;
    return q[q.size() - d];
  endfunction

  function automatic logic [3:0] m_pack(input int i);
    return {m_nor[i], m_w5[i], m_cont[i], m_flt[i]};
  endfunction

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i < 2; i++) begin
      m_nor[i]  = 1'b1;
      m_w5[i]   = 1'b1;
      m_cont[i] = 1'b0;
      m_flt[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit na, nb, pa, pb, pd, pu, nx_nor, nx_w5;
    for (int i = 0; i < 2; i++) begin
      na = gate_at(hist_a, dly_na[i]);
      nb = gate_at(hist_b, dly_nb[i]);
      pa = !gate_at(hist_a, dly_pa[i]);
      pb = !gate_at(hist_b, dly_pb[i]);
      pd = na || nb;
      pu = pa && pb;
      if (pa) nx_w5 = 1'b1;
      else if (pb && pd) nx_w5 = 1'b0;
      else nx_w5 = m_w5[i];
      if (pd) nx_nor = 1'b0;
      else if (pu) nx_nor = 1'b1;
      else if (pb) nx_nor = m_w5[i];
      else nx_nor = m_nor[i];
      m_w5[i]   = nx_w5;
      m_nor[i]  = nx_nor;
      m_cont[i] = pd && pu;
      m_flt[i]  = !pd && !pu;
    end
    hist_a.push_back(cur_a);
    hist_b.push_back(cur_b);
    if (hist_a.size() > 8) begin
      void'(hist_a.pop_front());
      void'(hist_b.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b);
    cur_a  = a;
    cur_b  = b;
    bus0.a = a;
    bus0.b = b;
    bus1.a = a;
    bus1.b = b;
  endtask

  // One rising edge with the model following it; returns at the falling edge for sampling.
  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) clock_edge();
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating} !== 4'b1100) begin
        miscompares++;
        $display("[TB] FAIL reset_dut0 cycle %0d: got %b expected 1100", i,
                 {bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating});
      end
      vectors++;
      if ({bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating} !== 4'b1100) begin
        miscompares++;
        $display("[TB] FAIL reset_dut1 cycle %0d: got %b expected 1100", i,
                 {bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_a_rise();
    applyStimulus(1'b0, 1'b0);
    settle(4);
    applyStimulus(1'b1, 1'b0);
    clock_edge();
    clock_edge();
    vectors++;
    if (bus0.nor_out !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rise_edge1_nor: got %b expected 1", bus0.nor_out);
    end
    clock_edge();
    vectors++;
    if ({bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL rise_edge2: got %b expected 0000",
               {bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating});
    end
  endtask

  task automatic test_a_fall();
    applyStimulus(1'b1, 1'b0);
    settle(4);
    applyStimulus(1'b0, 1'b0);
    clock_edge();
    clock_edge();
    vectors++;
    if ({bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating} !== 4'b0110) begin
      miscompares++;
      $display("[TB] FAIL fall_edge1: got %b expected 0110",
               {bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating});
    end
    clock_edge();
    vectors++;
    if ({bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL fall_edge2: got %b expected 1100",
               {bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating});
    end
  endtask

  task automatic test_slow_pullup();
    applyStimulus(1'b1, 1'b0);
    settle(5);
    applyStimulus(1'b0, 1'b0);
    clock_edge();
    clock_edge();
    vectors++;
    if ({bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL slow_edge1: got %b expected 0000",
               {bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating});
    end
    clock_edge();
    vectors++;
    if ({bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating} !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL slow_edge2: got %b expected 0001",
               {bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating});
    end
    clock_edge();
    vectors++;
    if ({bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL slow_edge3: got %b expected 1100",
               {bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating});
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] ab;
    for (int step = 0; step < 8; step++) begin
      ab = 2'(step);
      applyStimulus(ab[0], ab[1]);
      settle(3);
      vectors++;
      if (bus0.nor_out !== !(ab[0] || ab[1])) begin
        miscompares++;
        $display("[TB] FAIL truth_dut0 a=%b b=%b: got %b expected %b", ab[0], ab[1],
                 bus0.nor_out, !(ab[0] || ab[1]));
      end
      clock_edge();
      vectors++;
      if ({bus1.nor_out, bus1.contention, bus1.floating} !== {!(ab[0] || ab[1]), 2'b00}) begin
        miscompares++;
        $display("[TB] FAIL truth_dut1 a=%b b=%b: got %b expected %b", ab[0], ab[1],
                 {bus1.nor_out, bus1.contention, bus1.floating}, {!(ab[0] || ab[1]), 2'b00});
      end
      if (!ab[0]) begin
        vectors++;
        if (bus0.w5_node !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL truth_w5 a=0 b=%b: got %b expected 1", ab[1], bus0.w5_node);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(1'b0, 1'b0);
    settle(4);
    applyStimulus(1'b1, 1'b0);
    clock_edge();
    clock_edge();
    vectors++;
    if ({bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating} !== 4'b1101) begin
      miscompares++;
      $display("[TB] FAIL midrst_before: got %b expected 1101",
               {bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating});
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating,
         bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating} !== 8'b1100_1100) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: got %b expected 11001100",
               {bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating,
                bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clock_edge();
    clock_edge();
    vectors++;
    if ({bus0.nor_out, bus1.nor_out} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL midrst_edge1: got %b expected 11", {bus0.nor_out, bus1.nor_out});
    end
    clock_edge();
    vectors++;
    if ({bus0.nor_out, bus1.nor_out} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL midrst_edge2: got %b expected 00", {bus0.nor_out, bus1.nor_out});
    end
  endtask

  task automatic test_random();
    logic na;
    logic nb;
    for (int n = 0; n < 400; n++) begin
      na = ($urandom_range(0, 3) == 0) ? !cur_a : cur_a;
      nb = ($urandom_range(0, 3) == 0) ? !cur_b : cur_b;
      applyStimulus(na, nb);
      clock_edge();
      vectors++;
      if ({bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating} !== m_pack(0)) begin
        miscompares++;
        $display("[TB] FAIL random_dut0 step %0d: got %b expected %b", n,
                 {bus0.nor_out, bus0.w5_node, bus0.contention, bus0.floating}, m_pack(0));
      end
      vectors++;
      if ({bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating} !== m_pack(1)) begin
        miscompares++;
        $display("[TB] FAIL random_dut1 step %0d: got %b expected %b", n,
                 {bus1.nor_out, bus1.w5_node, bus1.contention, bus1.floating}, m_pack(1));
      end
      vectors++;
      if ((bus0.contention && bus0.floating) || (bus1.contention && bus1.floating)) begin
        miscompares++;
        $display("[TB] FAIL random_flags_exclusive step %0d: got %b%b %b%b expected not both set",
                 n, bus0.contention, bus0.floating, bus1.contention, bus1.floating);
      end
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
    model_reset();
    test_reset();
    test_a_rise();
    test_a_fall();
    test_slow_pullup();
    test_truth_table();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
